ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Source end of the keyboard_signal interface consumed by GameControl.
- Receives PS/2 keyboard frames, checks them, and decodes Set-2 scan codes into the 2-bit move code GameControl samples.
- Sits between the board PS/2 pins and GameControl.keyboard_signal.
- All logic is in the single system clock domain; the PS/2 lines are asynchronous inputs and are synchronised.

Parameters:
- HOLD_CYCLES, 50000: number of clk cycles keyboard_signal holds a decoded move before returning to 2'b00.
- TIMEOUT_CYCLES, 100000: idle clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 at a rising clk edge resets the block.
- ps2_clk  in  1  raw PS/2 clock line; asynchronous.
- ps2_data  in  1  raw PS/2 data line; asynchronous.
- keyboard_signal  out  2  move code: 00 none, 01 left, 10 right, 11 rotate.
- key_valid  out  1  one-cycle pulse in the first cycle a new code appears on keyboard_signal.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset values while rst==0:
  - keyboard_signal=00, key_valid=0, frame_err=0.
  - Frame FSM in IDLE; bit count, shift register, hold counter and timeout counter cleared.
  - ext_flag=0, brk_flag=0.
- Synchroniser and edge detect:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - A falling edge is sync_clk going 1 to 0 between consecutive cycles.
  - Data is sampled only on a detected falling edge.
- Frame FSM (11-bit frame):
  - IDLE: on a falling edge with data==0 (start bit), go to DATA with bit count 0. A falling edge with data==1 is ignored.
  - DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit and go to STOP.
  - STOP: the frame is good only if data==1 and the parity is odd (8 data bits plus parity bit have an odd number of 1s). Either way, return to IDLE.
- Timeout:
  - Outside IDLE, the timeout counter increments every cycle without a falling edge and clears on every edge.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and frame_err pulses.
- Error handling: a bad parity, bad stop bit or timeout pulses frame_err, drops the byte, and clears ext_flag and brk_flag.
- Byte decoder (good byte B, evaluated in the cycle after STOP):
  - B==E0: set ext_flag and emit nothing.
  - B==F0: set brk_flag and emit nothing.
  - Any other byte with brk_flag==1: release code. Emit nothing and clear both flags.
  - Any other byte with brk_flag==0 (make code): decode as below, emit if mapped, then clear ext_flag.
- Make-code map:
  - ext 6B or plain 1C (A): left, 01.
  - ext 74 or plain 23 (D): right, 10.
  - ext 75 or plain 1D (W): rotate, 11.
  - Any other code: nothing emitted.
- Emit rules:
  - On emit, keyboard_signal takes the code and key_valid pulses for exactly 1 cycle.
  - The hold counter loads HOLD_CYCLES-1 and decrements each cycle; when it reaches 0, keyboard_signal returns to 00.
  - Latency: the emit is visible 1 cycle after the FSM leaves STOP on a good frame.
- Typematic repeats: each repeated make code is a fresh emit.
- New emit during a hold: the new code replaces the old one at once, key_valid pulses, and the hold counter restarts. A repeat of the same code also pulses key_valid.
- Reset mid-frame or mid-hold: everything returns to its reset values at that edge; no partial byte is retained.
- ps2_clk stuck high: the FSM stays in IDLE indefinitely with no error.

Decomposition:
- Shared package holds:
  - Move-code constants KEY_NONE=2'b00, KEY_LEFT=2'b01, KEY_RIGHT=2'b10, KEY_ROTATE=2'b11 (shared with GameControl).
  - Scan-code constants SC_EXT=8'hE0 and SC_BREAK=8'hF0.
  - Key scan-code constants (6B, 74, 75, 1C, 23, 1D).
- One sub-module, ps2_frame_rx, covers the synchroniser, edge detect, frame FSM and timeout. It outputs byte[7:0], byte_valid and frame_err.
- The top level, ps2_key_decoder, holds the prefix flags, the key map and the hold counter.

Test Plan:
- Hold rst=0 for 3 cycles, then release while the PS/2 lines are idle high -> keyboard_signal==00, key_valid==0 and frame_err==0 throughout.
- Send valid frames E0 then 6B -> keyboard_signal==01 one cycle after the 6B stop bit, key_valid high for 1 cycle, and 00 again exactly HOLD_CYCLES cycles later (use HOLD_CYCLES=20 in the bench).
- Send 1D, then E0 F0 75 -> 11 emitted once for the 1D; no emit for the release sequence, and both flags clear afterwards.
- Send 23 with even parity -> frame_err pulses once and no emit. Then send 23 with odd parity -> keyboard_signal==10.
- Send 8 data bits, then stop toggling ps2_clk for TIMEOUT_CYCLES (use 100 in the bench) -> frame_err pulses and the FSM is in IDLE. A following 1C frame decodes to 01.
- Send 1C, then 23 five cycles into its hold -> the output switches 01 to 10 with a second key_valid pulse, and the hold restarts from 23.
- Assert rst=0 mid-hold or mid-frame -> outputs reset on that edge, and the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder_pkg
// Description : Shared definitions for the PS/2 keyboard front end.
//               - Move codes (also consumed by GameControl).
//               - PS/2 Set-2 prefix and key scan codes.
//               - Frame receiver state type.
//               - Make-code to move-code mapping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_key_decoder_pkg;

    // Move codes presented on keyboard_signal
    localparam logic [1:0] KEY_NONE   = 2'b00;
    localparam logic [1:0] KEY_LEFT   = 2'b01;
    localparam logic [1:0] KEY_RIGHT  = 2'b10;
    localparam logic [1:0] KEY_ROTATE = 2'b11;

    // Set-2 prefix bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    // Extended (E0-prefixed) arrow keys
    localparam logic [7:0] SC_EXT_LEFT   = 8'h6B;
    localparam logic [7:0] SC_EXT_RIGHT  = 8'h74;
    localparam logic [7:0] SC_EXT_ROTATE = 8'h75;

    // Plain letter keys A / D / W
    localparam logic [7:0] SC_KEY_A = 8'h1C;
    localparam logic [7:0] SC_KEY_D = 8'h23;
    localparam logic [7:0] SC_KEY_W = 8'h1D;

    // 11-bit frame receiver states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // Map a make code (with its extended-prefix flag) to a move code.
    // Unmapped codes return KEY_NONE.
    function automatic logic [1:0] map_make_code(input logic       ext,
                                                 input logic [7:0] code);
        logic [1:0] move;
        move = KEY_NONE;
        if (ext) begin
            case (code)
                SC_EXT_LEFT:   move = KEY_LEFT;
                SC_EXT_RIGHT:  move = KEY_RIGHT;
                SC_EXT_ROTATE: move = KEY_ROTATE;
                default:       move = KEY_NONE;
            endcase
        end else begin
            case (code)
                SC_KEY_A: move = KEY_LEFT;
                SC_KEY_D: move = KEY_RIGHT;
                SC_KEY_W: move = KEY_ROTATE;
                default:  move = KEY_NONE;
            endcase
        end
        return move;
    endfunction

endpackage : ps2_key_decoder_pkg
`default_nettype wire

// File: rtl/ps2_key_decoder_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_frame_rx
// Description : PS/2 11-bit frame receiver. Synchronises the raw PS/2 lines,
//               detects falling edges of the PS/2 clock, shifts in the data
//               byte LSB first, checks odd parity and the stop bit, and aborts
//               a frame that stalls between edges.
// Ports       : clk          - system clock
//               rst          - synchronous active-low reset
//               ps2_clk_i    - raw PS/2 clock (asynchronous)
//               ps2_data_i   - raw PS/2 data (asynchronous)
//               byte_o       - last good byte, valid with byte_valid_o
//               byte_valid_o - 1-cycle pulse after a good frame
//               frame_err_o  - 1-cycle pulse when a frame is discarded
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronisers; reset to the idle-high line level so that leaving reset
    // with idle lines does not look like a falling edge.
    logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic ps2_data_meta_q, ps2_data_sync_q;

    rx_state_e       state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            fall_edge;

    assign fall_edge = ps2_clk_prev_q & ~ps2_clk_sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_prev_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
            state_q         <= ST_IDLE;
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'h00;
            parity_q        <= 1'b0;
            tmo_q           <= '0;
            byte_q          <= 8'h00;
            byte_valid_q    <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            ps2_clk_meta_q  <= ps2_clk_i;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_prev_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data_i;
            ps2_data_sync_q <= ps2_data_meta_q;
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            parity_q        <= parity_d;
            tmo_q           <= tmo_d;
            byte_q          <= byte_d;
            byte_valid_q    <= byte_valid_d;
            frame_err_q     <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = '0;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        // Inter-edge watchdog runs only while a frame is in progress
        if (state_q != ST_IDLE && !fall_edge) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Only a low data line on the edge is a start bit
                if (fall_edge && !ps2_data_sync_q) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    shift_d   = {ps2_data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall_edge) begin
                    parity_d = ps2_data_sync_q;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    state_d = ST_IDLE;
                    // Odd parity over data+parity and a high stop bit
                    if (ps2_data_sync_q && (^{shift_q, parity_q})) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stalled frame: the count would reach TIMEOUT_CYCLES this cycle
        if (state_q != ST_IDLE && !fall_edge && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ST_IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule : ps2_frame_rx
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : PS/2 keyboard to move-code decoder. Tracks the E0/F0 prefix
//               state across received bytes, maps make codes to move codes
//               and holds each decoded move for HOLD_CYCLES clocks.
// Ports       : clk             - system clock
//               rst             - synchronous active-low reset
//               ps2_clk         - raw PS/2 clock (asynchronous)
//               ps2_data        - raw PS/2 data (asynchronous)
//               keyboard_signal - move code: 00 none, 01 left, 10 right,
//                                 11 rotate
//               key_valid       - 1-cycle pulse when a new code is emitted
//               frame_err       - 1-cycle pulse when a frame is discarded
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES    = 50000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [1:0] keyboard_signal,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_err;

    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [1:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    make_move;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err)
    );

    assign make_move = map_make_code(ext_q, rx_byte);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            key_q   <= KEY_NONE;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        key_d   = key_q;
        hold_d  = hold_q;
        valid_d = 1'b0;

        // Hold countdown; the move drops back to none after the cycle at 0
        if (key_q != KEY_NONE) begin
            if (hold_q == '0) begin
                key_d = KEY_NONE;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end

        if (rx_err) begin
            // A discarded frame breaks any prefix sequence in progress
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                // Release code: swallowed
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else begin
                ext_d = 1'b0;
                // A new make code (including a repeat) pre-empts any hold
                if (make_move != KEY_NONE) begin
                    key_d   = make_move;
                    hold_d  = HW'(HOLD_CYCLES - 1);
                    valid_d = 1'b1;
                end
            end
        end
    end

    assign keyboard_signal = key_q;
    assign key_valid       = valid_q;
    assign frame_err       = rx_err;

endmodule : ps2_key_decoder
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Self-checking bench for ps2_key_decoder. A short-hold
//               instance covers most scenarios; a long-hold instance sharing
//               the same PS/2 lines covers pre-emption during a hold, which
//               needs a hold longer than one frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int HOLD   = 20;
    localparam int HOLD_L = 60;
    localparam int TMO    = 100;
    localparam int LAT    = 4;   // stop-bit falling edge drive -> key_valid

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] ks, ks_l;
    logic       kv, kv_l, fe, fe_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_key_decoder #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_signal(ks), .key_valid(kv), .frame_err(fe)
    );

    ps2_key_decoder #(.HOLD_CYCLES(HOLD_L), .TIMEOUT_CYCLES(TMO)) dut_l (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_signal(ks_l), .key_valid(kv_l), .frame_err(fe_l)
    );

    // Output monitors: emitted codes with their cycle, hold-expiry cycles,
    // and frame error pulses.
    int         ev_cyc[$];
    logic [1:0] ev_code[$];
    int         zero_cyc[$];
    int         err_cnt = 0;
    int         evl_cyc[$];
    logic [1:0] evl_code[$];
    int         zerol_cyc[$];
    logic [1:0] ks_prev = 2'b00;
    logic [1:0] ksl_prev = 2'b00;

    always @(negedge clk) begin
        if (kv) begin ev_cyc.push_back(cyc); ev_code.push_back(ks); end
        if (kv_l) begin evl_cyc.push_back(cyc); evl_code.push_back(ks_l); end
        if (fe) err_cnt++;
        if (rst && ks_prev != 2'b00 && ks == 2'b00) zero_cyc.push_back(cyc);
        if (rst && ksl_prev != 2'b00 && ks_l == 2'b00) zerol_cyc.push_back(cyc);
        ks_prev  = ks;
        ksl_prev = ks_l;
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        ps2_clk = 1'b1; ps2_data = 1'b1; rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(5);
    endtask

    // Drive one 11-bit frame; returns the cycle the stop-bit falling edge was driven
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int half, output int stop_cyc);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        stop_cyc = 0;
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i]; ps2_clk = 1'b1; tick(half);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            tick(half);
        end
        ps2_clk = 1'b1; ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        int sc;
        send_frame(b, 1'b0, 1'b0, 3, sc);
    endtask

    // Reference: move code for a make byte given the E0 prefix
    function automatic logic [1:0] ref_move(input bit ext, input logic [7:0] b);
        if (ext && b == 8'h6B) return 2'b01;
        if (ext && b == 8'h74) return 2'b10;
        if (ext && b == 8'h75) return 2'b11;
        if (!ext && b == 8'h1C) return 2'b01;
        if (!ext && b == 8'h23) return 2'b10;
        if (!ext && b == 8'h1D) return 2'b11;
        return 2'b00;
    endfunction

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        int e0, v0;
        e0 = err_cnt; v0 = ev_cyc.size();
        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (ks !== 2'b00 || kv !== 1'b0 || fe !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got ks=%b kv=%b fe=%b want 00/0/0", ks, kv, fe);
            end
        end
        rst = 1'b1;
        // Idle-high lines for longer than the timeout: nothing may happen
        tick(3 * TMO);
        checks++;
        if (err_cnt - e0 != 0 || ev_cyc.size() - v0 != 0 || ks !== 2'b00) begin
            errors++;
            $display("FAIL idle_quiet: got errs=%0d emits=%0d ks=%b want 0/0/00",
                     err_cnt - e0, ev_cyc.size() - v0, ks);
        end
    endtask

    task automatic test_ext_left();
        int v0, z0, sc;
        do_reset();
        v0 = ev_cyc.size(); z0 = zero_cyc.size();
        send(8'hE0);
        send_frame(8'h6B, 1'b0, 1'b0, 3, sc);
        tick(HOLD + 10);
        checks++;
        if (ev_cyc.size() - v0 != 1) begin
            errors++;
            $display("FAIL ext_left_count: got %0d emits want 1", ev_cyc.size() - v0);
        end else begin
            checks++;
            if (ev_code[v0] !== 2'b01) begin
                errors++;
                $display("FAIL ext_left_code: got %b want 01", ev_code[v0]);
            end
            checks++;
            if (ev_cyc[v0] != sc + LAT) begin
                errors++;
                $display("FAIL ext_left_latency: got cycle %0d want %0d", ev_cyc[v0], sc + LAT);
            end
            checks++;
            if (zero_cyc.size() - z0 != 1 || zero_cyc[zero_cyc.size()-1] != ev_cyc[v0] + HOLD) begin
                errors++;
                $display("FAIL ext_left_hold: got %0d expiries, last at %0d want 1 at %0d",
                         zero_cyc.size() - z0,
                         (zero_cyc.size() > 0) ? zero_cyc[zero_cyc.size()-1] : -1,
                         ev_cyc[v0] + HOLD);
            end
        end
    endtask

    task automatic test_release();
        int v0;
        do_reset();
        v0 = ev_cyc.size();
        send(8'h1D); send(8'hE0); send(8'hF0); send(8'h75);
        tick(10);
        checks++;
        if (ev_cyc.size() - v0 != 1 || ev_code[ev_code.size()-1] !== 2'b11) begin
            errors++;
            $display("FAIL release_seq: got %0d emits last %b want 1 emit of 11",
                     ev_cyc.size() - v0, ev_code[ev_code.size()-1]);
        end
        // With both flags clear: 74 and 6B are plain and unmapped, 1C is a make
        v0 = ev_cyc.size();
        send(8'h74); send(8'h6B); send(8'h1C);
        tick(10);
        checks++;
        if (ev_cyc.size() - v0 != 1 || ev_code[ev_code.size()-1] !== 2'b01) begin
            errors++;
            $display("FAIL flags_cleared: got %0d emits last %b want 1 emit of 01",
                     ev_cyc.size() - v0, ev_code[ev_code.size()-1]);
        end
    endtask

    task automatic test_parity();
        int v0, e0, sc;
        do_reset();
        v0 = ev_cyc.size(); e0 = err_cnt;
        send_frame(8'h23, 1'b1, 1'b0, 3, sc);
        tick(10);
        checks++;
        if (err_cnt - e0 != 1 || ev_cyc.size() - v0 != 0) begin
            errors++;
            $display("FAIL bad_parity: got errs=%0d emits=%0d want 1/0", err_cnt - e0, ev_cyc.size() - v0);
        end
        send(8'h23);
        tick(10);
        checks++;
        if (ev_cyc.size() - v0 != 1 || ev_code[ev_code.size()-1] !== 2'b10) begin
            errors++;
            $display("FAIL good_parity: got %0d emits last %b want 1 emit of 10",
                     ev_cyc.size() - v0, ev_code[ev_code.size()-1]);
        end
        e0 = err_cnt; v0 = ev_cyc.size();
        send_frame(8'h1C, 1'b0, 1'b1, 3, sc);
        tick(10);
        checks++;
        if (err_cnt - e0 != 1 || ev_cyc.size() - v0 != 0) begin
            errors++;
            $display("FAIL bad_stop: got errs=%0d emits=%0d want 1/0", err_cnt - e0, ev_cyc.size() - v0);
        end
    endtask

    task automatic test_timeout();
        int v0, e0;
        logic [8:0] part;
        do_reset();
        send(8'hE0);   // prefix that the aborted frame must cancel
        v0 = ev_cyc.size(); e0 = err_cnt;
        part = {8'h1C, 1'b0};
        for (int i = 0; i < 9; i++) begin
            ps2_data = part[i]; ps2_clk = 1'b1; tick(3);
            ps2_clk = 1'b0; tick(3);
        end
        ps2_clk = 1'b1; ps2_data = 1'b1;
        tick(TMO - 20);
        checks++;
        if (err_cnt - e0 != 0) begin
            errors++;
            $display("FAIL timeout_early: got %0d errors before timeout want 0", err_cnt - e0);
        end
        tick(50);
        checks++;
        if (err_cnt - e0 != 1 || ev_cyc.size() - v0 != 0) begin
            errors++;
            $display("FAIL timeout_abort: got errs=%0d emits=%0d want 1/0", err_cnt - e0, ev_cyc.size() - v0);
        end
        send(8'h74);   // plain 74 is unmapped once the E0 is dropped
        send(8'h1C);
        tick(10);
        checks++;
        if (ev_cyc.size() - v0 != 1 || ev_code[ev_code.size()-1] !== 2'b01) begin
            errors++;
            $display("FAIL after_timeout: got %0d emits last %b want 1 emit of 01",
                     ev_cyc.size() - v0, ev_code[ev_code.size()-1]);
        end
    endtask

    task automatic test_back_to_back();
        int v0, z0, s1, s2, s3;
        logic [1:0] want [3];
        int         wcyc [3];
        do_reset();
        v0 = evl_cyc.size(); z0 = zerol_cyc.size();
        send_frame(8'h1C, 1'b0, 1'b0, 1, s1);
        send_frame(8'h23, 1'b0, 1'b0, 1, s2);
        send_frame(8'h23, 1'b0, 1'b0, 1, s3);
        tick(HOLD_L + 10);
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b10;
        wcyc[0] = s1 + LAT; wcyc[1] = s2 + LAT; wcyc[2] = s3 + LAT;
        checks++;
        if (evl_cyc.size() - v0 != 3) begin
            errors++;
            $display("FAIL preempt_count: got %0d emits want 3", evl_cyc.size() - v0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (evl_code[v0+i] !== want[i] || evl_cyc[v0+i] != wcyc[i]) begin
                    errors++;
                    $display("FAIL preempt_emit%0d: got %b at %0d want %b at %0d",
                             i, evl_code[v0+i], evl_cyc[v0+i], want[i], wcyc[i]);
                end
            end
        end
        // A single expiry, timed from the last emit, proves each emit restarted the hold
        checks++;
        if (zerol_cyc.size() - z0 != 1 || zerol_cyc[zerol_cyc.size()-1] != wcyc[2] + HOLD_L) begin
            errors++;
            $display("FAIL preempt_hold: got %0d expiries last %0d want 1 at %0d",
                     zerol_cyc.size() - z0,
                     (zerol_cyc.size() > 0) ? zerol_cyc[zerol_cyc.size()-1] : -1,
                     wcyc[2] + HOLD_L);
        end
    endtask

    task automatic test_reset_mid();
        int v0, e0;
        logic [4:0] part;
        do_reset();
        send(8'h1C);
        tick(LAT + 3);             // inside the hold
        rst = 1'b0;
        tick(1);
        checks++;
        if (ks !== 2'b00 || kv !== 1'b0 || fe !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got ks=%b kv=%b fe=%b want 00/0/0", ks, kv, fe);
        end
        tick(1);
        rst = 1'b1;
        tick(3);
        // Prefix plus a partial frame, then reset: neither may survive
        send(8'hE0);
        part = 5'b10100;
        for (int i = 0; i < 5; i++) begin
            ps2_data = part[i]; ps2_clk = 1'b1; tick(3);
            ps2_clk = 1'b0; tick(3);
        end
        ps2_clk = 1'b1; ps2_data = 1'b1;
        tick(1);
        rst = 1'b0; tick(2); rst = 1'b1; tick(3);
        v0 = ev_cyc.size(); e0 = err_cnt;
        send(8'h74);   // unmapped unless a stale E0 survived
        send(8'h1D);
        tick(10);
        checks++;
        if (ev_cyc.size() - v0 != 1 || ev_code[ev_code.size()-1] !== 2'b11 || err_cnt - e0 != 0) begin
            errors++;
            $display("FAIL reset_mid_frame: got %0d emits last %b errs %0d want 1 emit of 11, 0 errs",
                     ev_cyc.size() - v0, ev_code[ev_code.size()-1], err_cnt - e0);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [8];
        logic [1:0] exp_q[$];
        int         exp_err, v0, e0, sc, got;
        bit         ext, brk, bad_par, bad_stop;
        logic [7:0] b;
        logic [1:0] mv;
        pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h6B; pool[3] = 8'h74;
        pool[4] = 8'h75; pool[5] = 8'h1C; pool[6] = 8'h23; pool[7] = 8'h1D;
        do_reset();
        ext = 0; brk = 0; exp_err = 0;
        v0 = ev_cyc.size(); e0 = err_cnt;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            else                            b = pool[$urandom_range(0, 7)];
            bad_par = 0; bad_stop = 0;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) bad_stop = 1; else bad_par = 1;
            end
            send_frame(b, bad_par, bad_stop, $urandom_range(1, 4), sc);
            if (bad_par || bad_stop) begin
                exp_err++; ext = 0; brk = 0;
            end else if (b == 8'hE0) begin
                ext = 1;
            end else if (b == 8'hF0) begin
                brk = 1;
            end else if (brk) begin
                ext = 0; brk = 0;
            end else begin
                mv = ref_move(ext, b);
                if (mv != 2'b00) exp_q.push_back(mv);
                ext = 0;
            end
        end
        tick(10);
        got = ev_cyc.size() - v0;
        checks++;
        if (got != exp_q.size() || err_cnt - e0 != exp_err) begin
            errors++;
            $display("FAIL random_counts: got %0d emits %0d errs want %0d emits %0d errs",
                     got, err_cnt - e0, exp_q.size(), exp_err);
        end
        for (int i = 0; i < exp_q.size() && i < got; i++) begin
            checks++;
            if (ev_code[v0+i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_emit%0d: got %b want %b", i, ev_code[v0+i], exp_q[i]);
            end
        end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_ext_left();
        test_release();
        test_parity();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ps2_key_decoder
`default_nettype wire
